// File: rtl/reg_xfer_seq.sv
// Scratch-pad transfer sequencer: IDLE->READ->WRITE->DONE, 4 cycles per legal request, 2 per illegal one.
// No request queue: start is sampled only in IDLE. Optional INR/DCR path under `REG_XFER_INC_DEC_EN.
module reg_xfer_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [2:0] dst,
  input  logic [2:0] src,
  input  logic [7:0] sp_out,
  output logic [6:0] rs,
  output logic       we,
  output logic [7:0] sp_in,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_INR = 2'b01;
  localparam logic [1:0] OP_DCR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [2:0] REG_M  = 3'd7;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_op;
  logic [2:0] r_dst;
  logic [2:0] r_src;
  logic [7:0] r_temp;
  logic       r_err;
  logic       w_illegal;

  function automatic logic [6:0] onehot7(input logic [2:0] code);
    onehot7 = 7'b1 << code;
  endfunction

  always_comb begin
    w_illegal = (dst == REG_M) || (op == OP_RSV) || ((op == OP_MOV) && (src == REG_M));
`ifndef REG_XFER_INC_DEC_EN
    w_illegal = w_illegal || (op == OP_INR) || (op == OP_DCR);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_MOV;
      r_dst   <= 3'd0;
      r_src   <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_op  <= op;
        r_dst <= dst;
        r_src <= src;
        r_err <= w_illegal;
      end else if (r_state == S_DONE) begin
        r_err <= 1'b0;
      end
    end
  end

  // Temp captures the (optionally adjusted) source during READ; it is the write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_temp <= 8'h00;
    end else if (r_state == S_READ) begin
`ifdef REG_XFER_INC_DEC_EN
      case (r_op)
        OP_INR:  r_temp <= sp_out + 8'd1;
        OP_DCR:  r_temp <= sp_out - 8'd1;
        default: r_temp <= sp_out;
      endcase
`else
      r_temp <= sp_out;
`endif
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_illegal ? S_DONE : S_READ;
      S_READ:  w_next = S_WRITE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decode only state and latched fields, so reset removes we/rs at once.
  always_comb begin
    rs   = 7'd0;
    we   = 1'b0;
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
    err  = (r_state == S_DONE) && r_err;
    case (r_state)
      S_READ:  rs = (r_op == OP_MOV) ? onehot7(r_src) : onehot7(r_dst);
      S_WRITE: begin
        rs = onehot7(r_dst);
        we = 1'b1;
      end
      default: rs = 7'd0;
    endcase
  end

  assign sp_in = r_temp;

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Bench for reg_xfer_seq: scratch-pad model, reference register file and an expectation queue.
module tb_reg_xfer_seq;

`ifdef REG_XFER_INC_DEC_EN
  localparam bit IDE = 1'b1;
`else
  localparam bit IDE = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic [2:0] dst;
  logic [2:0] src;
  logic [7:0] sp_out;
  logic [6:0] rs;
  logic       we;
  logic [7:0] sp_in;
  logic       busy;
  logic       done;
  logic       err;

  reg_xfer_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dst(dst), .src(src),
    .sp_out(sp_out), .rs(rs), .we(we), .sp_in(sp_in), .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  // Scratch-pad model driven by the DUT, with a preload port for the bench.
  logic [7:0] mem [7];
  logic       pl_en;
  logic [2:0] pl_idx;
  logic [7:0] pl_dat;

  function automatic int oh2idx(input logic [6:0] v);
    oh2idx = 0;
    for (int i = 0; i < 7; i++) if (v[i]) oh2idx = i;
  endfunction

  assign sp_out = mem[oh2idx(rs)];

  always @(posedge clk) begin
    if (we) mem[oh2idx(rs)] <= sp_in;
    else if (pl_en) mem[pl_idx] <= pl_dat;
  end

  typedef struct {
    logic [1:0] op;
    logic [2:0] dst;
    logic [2:0] src;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic       err;
    logic [6:0] rs;
    logic [7:0] dat;
    int         idx;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mdl_r [7];
  vec_t       vecs [10];
  int         n_chk;
  int         n_fail;
  int         n_done;
  int         we_cnt;
  logic [6:0] we_rs;
  logic [7:0] we_dat;
  bit         got_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle observer, called at every falling edge.
  task automatic mon();
    exp_t e;
    if (!rst_n) begin
      q.delete();
      we_cnt = 0;
      return;
    end
    chk("rs_onehot_or_zero", 32'((rs == 7'd0) || $onehot(rs)), 32'd1);
    if (err && !done) chk("err_without_done", 32'(err), 32'd0);
    if (we) begin
      we_cnt++;
      we_rs  = rs;
      we_dat = sp_in;
    end
    if (done) begin
      n_done++;
      got_done = 1'b1;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("err_flag", 32'(err), 32'(e.err));
        chk("we_count", 32'(we_cnt), e.err ? 32'd0 : 32'd1);
        if (!e.err) begin
          chk("we_rs", 32'(we_rs), 32'(e.rs));
          chk("write_data", 32'(we_dat), 32'(e.dat));
          mdl_r[e.idx] = e.dat;
        end
      end
      we_cnt = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic push(input logic [1:0] o, input logic [2:0] d, input logic [2:0] s,
                      input logic e_err);
    exp_t e;
    e.err = e_err;
    e.rs  = 7'd0;
    e.dat = 8'h00;
    e.idx = 0;
    if (!e_err) begin
      e.rs  = 7'b1 << d;
      e.idx = int'(d);
      case (o)
        2'b01:   e.dat = mdl_r[d] + 8'd1;
        2'b10:   e.dat = mdl_r[d] - 8'd1;
        default: e.dat = mdl_r[s];
      endcase
    end
    q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] o, input logic [2:0] d, input logic [2:0] s);
    start = 1'b1;
    op    = o;
    dst   = d;
    src   = s;
  endtask

  // One full request; returns with the DUT back in IDLE at a falling edge.
  task automatic do_req(input logic [1:0] o, input logic [2:0] d, input logic [2:0] s,
                        input logic e_err);
    int n;
    got_done = 1'b0;
    drive(o, d, s);
    push(o, d, s, e_err);
    tick();
    start = 1'b0;
    n = 0;
    while (!got_done && n < 8) begin
      tick();
      n++;
    end
    if (!got_done) chk("done_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic preload(input logic [2:0] idx, input logic [7:0] dat);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_dat = dat;
    mdl_r[idx] = dat;
    tick();
    pl_en = 1'b0;
  endtask

  initial begin
    int d0;
    vecs[0] = '{2'b00, 3'd2, 3'd0, 1'b0};   // MOV C,A
    vecs[1] = '{2'b00, 3'd3, 3'd3, 1'b0};   // MOV D,D
    vecs[2] = '{2'b00, 3'd0, 3'd7, 1'b1};   // MOV A,M
    vecs[3] = '{2'b11, 3'd1, 3'd2, 1'b1};   // reserved op
    vecs[4] = '{2'b00, 3'd7, 3'd7, 1'b1};   // MOV M,M
    vecs[5] = '{2'b01, 3'd6, 3'd0, !IDE};   // INR L (L=FF)
    vecs[6] = '{2'b10, 3'd6, 3'd0, !IDE};   // DCR L
    vecs[7] = '{2'b01, 3'd3, 3'd0, !IDE};   // INR D
    vecs[8] = '{2'b00, 3'd6, 3'd5, 1'b0};   // MOV L,H
    vecs[9] = '{2'b10, 3'd1, 3'd0, !IDE};   // DCR B

    n_chk = 0; n_fail = 0; n_done = 0; we_cnt = 0;
    we_rs = 7'd0; we_dat = 8'h00; got_done = 1'b0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; dst = 3'd0; src = 3'd0;
    pl_en = 1'b0; pl_idx = 3'd0; pl_dat = 8'h00;

    #1;
    chk("reset_rs", 32'(rs), 32'd0);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_sp_in", 32'(sp_in), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    preload(3'd0, 8'h11); preload(3'd1, 8'h5A); preload(3'd2, 8'h33);
    preload(3'd3, 8'h44); preload(3'd4, 8'h55); preload(3'd5, 8'h66);
    preload(3'd6, 8'hFF);
    tick();

    // MOV A,B cycle by cycle
    drive(2'b00, 3'd0, 3'd1);
    push(2'b00, 3'd0, 3'd1, 1'b0);
    tick();
    start = 1'b0;
    chk("movab_c1_rs", 32'(rs), 32'h02);
    chk("movab_c1_we", 32'(we), 32'd0);
    chk("movab_c1_busy", 32'(busy), 32'd1);
    tick();
    chk("movab_c2_rs", 32'(rs), 32'h01);
    chk("movab_c2_we", 32'(we), 32'd1);
    chk("movab_c2_sp_in", 32'(sp_in), 32'h5A);
    tick();
    chk("movab_c3_done", 32'(done), 32'd1);
    chk("movab_c3_err", 32'(err), 32'd0);
    chk("movab_c3_rs", 32'(rs), 32'd0);
    tick();
    chk("movab_c4_busy", 32'(busy), 32'd0);
    chk("movab_c4_done", 32'(done), 32'd0);
    chk("movab_result_A", 32'(mem[0]), 32'h5A);

    // MOV M,C: error in cycle 1
    drive(2'b00, 3'd7, 3'd2);
    push(2'b00, 3'd7, 3'd2, 1'b1);
    tick();
    start = 1'b0;
    chk("movmc_c1_done", 32'(done), 32'd1);
    chk("movmc_c1_err", 32'(err), 32'd1);
    chk("movmc_c1_we", 32'(we), 32'd0);
    tick();
    chk("movmc_c2_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++)
      do_req(vecs[i].op, vecs[i].dst, vecs[i].src, vecs[i].exp_err);

    // start pulses during a running MOV D,E are ignored
    d0 = n_done;
    drive(2'b00, 3'd3, 3'd4);
    push(2'b00, 3'd3, 3'd4, 1'b0);
    tick();
    drive(2'b00, 3'd0, 3'd2);
    tick();
    tick();
    start = 1'b0;
    tick();
    chk("ignore_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("ignore_done_count", 32'(n_done - d0), 32'd1);

    // start held high: accepts every 4 cycles
    d0 = n_done;
    drive(2'b00, 3'd1, 3'd0);
    push(2'b00, 3'd1, 3'd0, 1'b0);
    push(2'b00, 3'd1, 3'd0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    start = 1'b0;
    tick();
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_done_count", 32'(n_done - d0), 32'd2);

    // Reset during WRITE of MOV H,A
    drive(2'b00, 3'd5, 3'd0);
    push(2'b00, 3'd5, 3'd0, 1'b0);
    tick();
    start = 1'b0;
    tick();
    chk("rstw_we_before", 32'(we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_we_async", 32'(we), 32'd0);
    chk("rstw_rs_async", 32'(rs), 32'd0);
    tick();
    rst_n = 1'b1;
    chk("rstw_busy_after", 32'(busy), 32'd0);
    chk("rstw_sp_in_after", 32'(sp_in), 32'd0);
    chk("rstw_H_unchanged", 32'(mem[5]), 32'(mdl_r[5]));
    tick();
    do_req(2'b00, 3'd5, 3'd0, 1'b0);

    for (int i = 0; i < 7; i++) chk($sformatf("final_reg%0d", i), 32'(mem[i]), 32'(mdl_r[i]));
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
